// File: rtl/dff_reg_arbiter.sv
// Two-master round-robin front end for a shared WIDTH-bit D flip-flop register.
// Each grant runs a fixed IDLE->GRANT->APPLY->DONE sequence; q_bar tracks ~q_out.
module dff_reg_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req0,
   input  logic [1:0]       op0,
   input  logic [WIDTH-1:0] d0,
   input  logic             req1,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] d1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] q_bar
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      APPLY = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_PRESET = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;

   state_t           state;
   state_t           state_nx;
   logic             gnt0_nx;
   logic             gnt1_nx;
   logic             done_nx;
   logic             busy_nx;
   logic             ptr;
   logic             ptr_nx;
   logic             pick;
   logic             req_g;
   logic [1:0]       op_r;
   logic [1:0]       op_nx;
   logic [WIDTH-1:0] d_r;
   logic [WIDTH-1:0] d_nx;
   logic [WIDTH-1:0] q_nx;

   assign q_bar = ~q_out;

   always_comb begin
      state_nx = state;
      gnt0_nx  = gnt0;
      gnt1_nx  = gnt1;
      done_nx  = 1'b0;
      busy_nx  = busy;
      ptr_nx   = ptr;
      op_nx    = op_r;
      d_nx     = d_r;
      q_nx     = q_out;
      pick     = 1'b0;
      req_g    = gnt1 ? req1 : req0;
      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               // pick=1 selects master 1: sole requester, or tie with ptr on 1
               pick     = req1 && (!req0 || ptr);
               gnt0_nx  = !pick;
               gnt1_nx  = pick;
               busy_nx  = 1'b1;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            if (req_g) begin
               op_nx    = gnt1 ? op1 : op0;
               d_nx     = gnt1 ? d1 : d0;
               state_nx = APPLY;
            end else begin
               gnt0_nx  = 1'b0;
               gnt1_nx  = 1'b0;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end
         end
         APPLY: begin
            unique case (op_r)
               OP_LOAD:   q_nx = d_r;
               OP_PRESET: q_nx = '1;
               OP_CLEAR:  q_nx = '0;
               default:   q_nx = q_out;
            endcase
            done_nx  = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            gnt0_nx  = 1'b0;
            gnt1_nx  = 1'b0;
            busy_nx  = 1'b0;
            ptr_nx   = gnt0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
         ptr   <= 1'b0;
         op_r  <= 2'b00;
         d_r   <= '0;
         q_out <= '0;
      end else begin
         state <= state_nx;
         gnt0  <= gnt0_nx;
         gnt1  <= gnt1_nx;
         done  <= done_nx;
         busy  <= busy_nx;
         ptr   <= ptr_nx;
         op_r  <= op_nx;
         d_r   <= d_nx;
         q_out <= q_nx;
      end
   end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboarded bench for dff_reg_arbiter: each completion pops the expected
// master and register value; direct checks cover reset, abort and timing.
module tb_dff_reg_arbiter;

   localparam int W = 8;

   logic         clk;
   logic         clr;
   logic         req0;
   logic [1:0]   op0;
   logic [W-1:0] d0;
   logic         req1;
   logic [1:0]   op1;
   logic [W-1:0] d1;
   logic         gnt0;
   logic         gnt1;
   logic         done;
   logic         busy;
   logic [W-1:0] q_out;
   logic [W-1:0] q_bar;

   int n_chk;
   int n_fail;
   int done_cnt;
   logic done_prev;
   logic [W:0] sb[$];

   dff_reg_arbiter #(.WIDTH(W)) dut (
      .clk  (clk),
      .clr  (clr),
      .req0 (req0),
      .op0  (op0),
      .d0   (d0),
      .req1 (req1),
      .op1  (op1),
      .d1   (d1),
      .gnt0 (gnt0),
      .gnt1 (gnt1),
      .done (done),
      .busy (busy),
      .q_out(q_out),
      .q_bar(q_bar)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Completion monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      check("excl", {31'd0, gnt0 & gnt1}, 32'd0);
      check("qbar", {24'd0, q_bar}, {24'd0, ~q_out});
      if (done) begin
         done_cnt++;
         check("done_pulse", {31'd0, done_prev}, 32'd0);
         check("done_gnt", {31'd0, gnt0 ^ gnt1}, 32'd1);
         if (sb.size() == 0) begin
            check("done_unexp", 32'd1, 32'd0);
         end else begin
            logic [W:0] e;
            e = sb.pop_front();
            check("sb_master", {31'd0, gnt1}, {31'd0, e[W]});
            check("sb_q", {24'd0, q_out}, {24'd0, e[W-1:0]});
         end
      end
      done_prev = done;
   end

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            break;
         end
      end
      if (n == 0) check("timeout", 32'd1, 32'd0);
   endtask

   task automatic serve(input logic m, input logic [1:0] op,
                        input logic [W-1:0] d, input logic [W-1:0] exp_q);
      int n;
      sb.push_back({m, exp_q});
      if (m) begin
         req1 = 1'b1; op1 = op; d1 = d;
      end else begin
         req0 = 1'b1; op0 = op; d0 = d;
      end
      wait_done(n);
      check("latency", n, 32'd3);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      int base;
      n_chk = 0; n_fail = 0; done_cnt = 0; done_prev = 1'b0;
      clr = 1'b0;
      req0 = 1'b0; op0 = 2'b00; d0 = '0;
      req1 = 1'b0; op1 = 2'b00; d1 = '0;

      #3;
      check("rst_q", {24'd0, q_out}, 32'h00);
      check("rst_qbar", {24'd0, q_bar}, 32'hFF);
      check("rst_flags", {28'd0, gnt0, gnt1, done, busy}, 32'd0);
      @(negedge clk);
      clr = 1'b1;

      // Single load with timing detail; d0 changes after capture are ignored
      sb.push_back({1'b0, 8'hA5});
      req0 = 1'b1; op0 = 2'b00; d0 = 8'hA5;
      @(negedge clk);
      check("e0_gnt", {30'd0, gnt0, gnt1}, 32'd2);
      check("e0_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("e1_q", {24'd0, q_out}, 32'h00);
      d0 = 8'hFF;
      @(negedge clk);
      check("e2_done", {31'd0, done}, 32'd1);
      check("e2_qbar", {24'd0, q_bar}, 32'h5A);
      req0 = 1'b0;
      @(negedge clk);
      check("e3_flags", {28'd0, gnt0, gnt1, done, busy}, 32'd0);

      serve(1'b1, 2'b01, 8'h12, 8'hFF);
      serve(1'b1, 2'b10, 8'h34, 8'h00);
      serve(1'b0, 2'b00, 8'hC3, 8'hC3);
      serve(1'b0, 2'b11, 8'h99, 8'hC3);

      // Contention from reset: strict alternation starting with master 0
      #2 clr = 1'b0;
      #1 check("rst2_q", {24'd0, q_out}, 32'h00);
      @(negedge clk);
      clr = 1'b1;
      sb.push_back({1'b0, 8'h11});
      sb.push_back({1'b1, 8'h22});
      sb.push_back({1'b0, 8'h11});
      sb.push_back({1'b1, 8'h22});
      op0 = 2'b00; d0 = 8'h11; op1 = 2'b00; d1 = 8'h22;
      req0 = 1'b1; req1 = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      check("cont_cnt", n, 32'd4);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("cont_q", {24'd0, q_out}, 32'h22);

      // Abort: req0 drops during GRANT
      base = done_cnt;
      req0 = 1'b1; op0 = 2'b00; d0 = 8'h77;
      @(negedge clk);
      check("ab_gnt", {31'd0, gnt0}, 32'd1);
      req0 = 1'b0;
      @(negedge clk);
      check("ab_idle", {28'd0, gnt0, gnt1, done, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("ab_q", {24'd0, q_out}, 32'h22);
      check("ab_done", done_cnt - base, 32'd0);

      // Tie after abort still favours master 0
      sb.push_back({1'b0, 8'h33});
      op0 = 2'b00; d0 = 8'h33; op1 = 2'b00; d1 = 8'h44;
      req0 = 1'b1; req1 = 1'b1;
      wait_done(n);
      check("tie_lat", n, 32'd3);
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in the APPLY cycle
      base = done_cnt;
      req0 = 1'b1; op0 = 2'b00; d0 = 8'h3C;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("ra_q", {24'd0, q_out}, 32'h00);
      check("ra_qbar", {24'd0, q_bar}, 32'hFF);
      check("ra_flags", {28'd0, gnt0, gnt1, done, busy}, 32'd0);
      @(negedge clk);
      clr = 1'b1;
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      check("ra_done", done_cnt - base, 32'd0);
      check("ra_q2", {24'd0, q_out}, 32'h00);
      check("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dff_reg_arbiter.md
# dff_reg_arbiter

Two-requester round-robin controller that shares one WIDTH-bit storage register, built as a bank of D flip-flops with clear/preset, between two write masters. Each master requests an operation (load, preset-all, clear-all, no-op). The block arbitrates, sequences the operation into the register through a fixed four-state handshake, and reports completion. It sits between the lab's D flip-flop storage element and any two agents that must update it, such as a keypad capture unit and a test stimulus driver.

## Interface

- WIDTH, 8, storage register width in bits (1..32)

- clk  in  1  rising-edge clock
- clr  in  1  reset; asynchronous, active-low
- req0  in  1  request from master 0; held high until done
- op0  in  2  master 0 operation: 00 load, 01 preset-all, 10 clear-all, 11 no-op
- d0  in  WIDTH  master 0 load data
- req1  in  1  request from master 1
- op1  in  2  master 1 operation, same encoding
- d1  in  WIDTH  master 1 load data
- gnt0  out  1  master 0 owns the register
- gnt1  out  1  master 1 owns the register
- done  out  1  one-cycle completion pulse to the granted master
- busy  out  1  high in any state other than IDLE
- q_out  out  WIDTH  register contents
- q_bar  out  WIDTH  bitwise complement of q_out, always

## Operation

- Reset (clr low, asynchronous) forces state IDLE, q_out=0, q_bar=all ones, gnt0=gnt1=0, done=0, busy=0, and priority pointer=0 (master 0 favoured).
- FSM states: IDLE, GRANT, APPLY, DONE. All outputs are registered.
- IDLE: if no request is present, stay. If only one master requests, grant it. If both request, grant the master named by the pointer. Then move to GRANT with the matching gntN=1 and busy=1.
- GRANT: if the granted master's req is still high, capture its op and d into internal registers and move to APPLY. If that req has dropped, abort: return to IDLE, gnt=0, no write, no done, pointer unchanged.
- APPLY: perform the captured operation on the register:
  - load: q_out=d
  - preset-all: q_out=all ones
  - clear-all: q_out=0
  - no-op: q_out unchanged
  - Then move to DONE with done=1.
- DONE: done returns to 0 and gnt returns to 0. The pointer is set to the other master (the one not just served). Return to IDLE.
- The register changes only on the APPLY edge. It is never written by the non-granted master.
- req, op and d from the granted master must be stable from request until done. Changes after the GRANT capture edge have no effect.
- Fairness: with both masters requesting continuously, grants strictly alternate.

## Timing

- Edge E0: req sampled in IDLE. gnt high after E0.
- Edge E1: op/d captured.
- Edge E2: q_out/q_bar update, and done goes high for exactly one cycle.
- Edge E3: gnt and done go low, busy goes low, and the block is back in IDLE.
- Minimum request-to-request service spacing is 4 cycles. A request held through E3 is re-arbitrated at E4.
- A request that arrives while busy waits and is not lost. It is sampled at the next IDLE edge.
- gnt0 and gnt1 are never high together. done is high only while the corresponding gnt is high.
- Reset mid-operation (any state): the operation is aborted immediately, the register is cleared, and no done is issued.
- q_bar equals ~q_out on every cycle, including during reset.

## Test plan

- Reset: drive clr=0 at an arbitrary time -> q_out=0x00, q_bar=0xFF, gnt0=gnt1=done=busy=0, asynchronously with no clk edge required.
- Single load: req0=1, op0=00, d0=0xA5 -> gnt0 high after E0, q_out=0xA5 and q_bar=0x5A after E2, done pulse for one cycle, idle after E3.
- Preset then clear by master 1: op1=01 -> q_out=0xFF. Next request op1=10 -> q_out=0x00. Each operation takes 4 cycles.
- Simultaneous contention: from reset, req0=req1=1 held with d0=0x11, d1=0x22 -> grant order 0,1,0,1. q_out sequence is 0x11, 0x22, 0x11. gnt0 and gnt1 are never high together.
- Abort: master 0 requests, then drops req0 during GRANT -> return to IDLE, q_out unchanged, no done, next tie still favours master 0.
- Reset mid-APPLY: issue load 0x3C and pull clr low in the APPLY cycle -> q_out=0x00, no done pulse, state IDLE.
